// File: rtl/alu_chk_pkg.sv
// Shared types and constants for the ALU pair checker.
package alu_chk_pkg;

    localparam int OPC_W     = 3;
    localparam int NUM_OPC   = 8;
    localparam int CNT_W     = 16;
    localparam int OPC_CNT_W = 8;
    localparam int WAIT_W    = 4;

    // err_code bit positions
    localparam int ERR_DATA = 0;
    localparam int ERR_FLAG = 1;
    localparam int ERR_CONS = 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CMP,
        S_REPORT
    } state_e;

    // Saturating increment for the 16-bit totals.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Saturating increment for the per-opcode counters.
    function automatic logic [OPC_CNT_W-1:0] sat_inc_opc(input logic [OPC_CNT_W-1:0] v);
        return (v == {OPC_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_pair_checker_if.sv
// Sample request bus: ALU pair results plus the valid/ready handshake.
interface alu_pair_checker_if #(
    parameter int W = 16
);
    import alu_chk_pkg::*;

    logic             smp_valid;
    logic             smp_ready;
    logic [OPC_W-1:0] opc;
    logic [W-1:0]     out1;
    logic [W-1:0]     out2;
    logic             zer1;
    logic             neg1;
    logic             zer2;
    logic             neg2;

    modport master (
        output smp_valid, opc, out1, out2, zer1, neg1, zer2, neg2,
        input  smp_ready
    );

    modport slave (
        input  smp_valid, opc, out1, out2, zer1, neg1, zer2, neg2,
        output smp_ready
    );
endinterface

// File: rtl/alu_flag_check.sv
// Checks that one ALU's zero/negative flags agree with its own result.
module alu_flag_check #(
    parameter int W = 16
) (
    input  logic [W-1:0] data,
    input  logic         zer,
    input  logic         neg,
    output logic         ok
);
    // Consistent when zer tracks data==0 and neg tracks the sign bit.
    always_comb begin
        ok = (zer == (data == '0)) && (neg == data[W-1]);
    end
endmodule

// File: rtl/alu_pair_checker.sv
// Compares two ALU implementations after a settle delay and keeps
// pass/fail statistics plus a record of the first failure.
module alu_pair_checker
    import alu_chk_pkg::*;
#(
    parameter int W      = 16,
    parameter int SETTLE = 4    // legal 1..15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    alu_pair_checker_if.slave    smp,
    output logic                 chk_done,
    output logic                 chk_fail,
    output logic [2:0]           err_code,
    output logic [CNT_W-1:0]     total_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    input  logic [OPC_W-1:0]     opc_sel,
    output logic [OPC_CNT_W-1:0] opc_fail_cnt,
    output logic                 first_vld,
    output logic [OPC_W-1:0]     first_opc,
    output logic [W-1:0]         first_out1,
    output logic [W-1:0]         first_out2
);

    state_e             state_q;
    logic [WAIT_W-1:0]  wait_q;
    logic [OPC_W-1:0]   opc_q;
    logic [W-1:0]       d1_q, d2_q;
    logic [2:0]         err_q;
    logic               done_q;

    logic               ok1, ok2;
    logic [2:0]         err_nxt;

    logic [CNT_W-1:0]                        total_q, total_d;
    logic [CNT_W-1:0]                        fail_q, fail_d;
    logic [NUM_OPC-1:0][OPC_CNT_W-1:0]       opc_cnt_q, opc_cnt_d;
    logic                                    first_vld_q, first_vld_d;
    logic [OPC_W-1:0]                        first_opc_q, first_opc_d;
    logic [W-1:0]                            first_out1_q, first_out1_d;
    logic [W-1:0]                            first_out2_q, first_out2_d;

    alu_flag_check #(.W(W)) u_flag1 (
        .data (smp.out1),
        .zer  (smp.zer1),
        .neg  (smp.neg1),
        .ok   (ok1)
    );

    alu_flag_check #(.W(W)) u_flag2 (
        .data (smp.out2),
        .zer  (smp.zer2),
        .neg  (smp.neg2),
        .ok   (ok2)
    );

    // Error classification of the live ALU outputs, sampled in CMP.
    always_comb begin
        err_nxt           = '0;
        err_nxt[ERR_DATA] = (smp.out1 != smp.out2);
        err_nxt[ERR_FLAG] = ({smp.zer1, smp.neg1} != {smp.zer2, smp.neg2});
        err_nxt[ERR_CONS] = !ok1 || !ok2;
    end

    // Check sequencer: accept, settle, compare, report; clr aborts to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            opc_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else if (clr) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (smp.smp_valid) begin
                        opc_q   <= smp.opc;
                        wait_q  <= WAIT_W'(SETTLE - 1);
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (wait_q == '0) state_q <= S_CMP;
                    else              wait_q  <= wait_q - 1'b1;
                end
                S_CMP: begin
                    d1_q    <= smp.out1;
                    d2_q    <= smp.out2;
                    err_q   <= err_nxt;
                    done_q  <= 1'b1;
                    state_q <= S_REPORT;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Statistics and first-fail record update; clr takes priority over REPORT.
    always_comb begin
        total_d      = total_q;
        fail_d       = fail_q;
        opc_cnt_d    = opc_cnt_q;
        first_vld_d  = first_vld_q;
        first_opc_d  = first_opc_q;
        first_out1_d = first_out1_q;
        first_out2_d = first_out2_q;
        if (clr) begin
            total_d      = '0;
            fail_d       = '0;
            opc_cnt_d    = '0;
            first_vld_d  = 1'b0;
            first_opc_d  = '0;
            first_out1_d = '0;
            first_out2_d = '0;
        end else if (state_q == S_REPORT) begin
            total_d = sat_inc_cnt(total_q);
            if (|err_q) begin
                fail_d           = sat_inc_cnt(fail_q);
                opc_cnt_d[opc_q] = sat_inc_opc(opc_cnt_q[opc_q]);
                if (!first_vld_q) begin
                    first_vld_d  = 1'b1;
                    first_opc_d  = opc_q;
                    first_out1_d = d1_q;
                    first_out2_d = d2_q;
                end
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q      <= '0;
            fail_q       <= '0;
            opc_cnt_q    <= '0;
            first_vld_q  <= 1'b0;
            first_opc_q  <= '0;
            first_out1_q <= '0;
            first_out2_q <= '0;
        end else begin
            total_q      <= total_d;
            fail_q       <= fail_d;
            opc_cnt_q    <= opc_cnt_d;
            first_vld_q  <= first_vld_d;
            first_opc_q  <= first_opc_d;
            first_out1_q <= first_out1_d;
            first_out2_q <= first_out2_d;
        end
    end

    // Outputs; a clr in the REPORT cycle masks the done pulse.
    always_comb begin
        smp.smp_ready = (state_q == S_IDLE);
        chk_done      = done_q && !clr;
        chk_fail      = |err_q;
        err_code      = err_q;
        total_cnt     = total_q;
        fail_cnt      = fail_q;
        opc_fail_cnt  = opc_cnt_q[opc_sel];
        first_vld     = first_vld_q;
        first_opc     = first_opc_q;
        first_out1    = first_out1_q;
        first_out2    = first_out2_q;
    end

endmodule

// File: tb/tb_alu_pair_checker.sv
// Directed bench for alu_pair_checker with hand-computed expectations.
module tb_alu_pair_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        chk_done, chk_fail;
    logic [2:0]  err_code;
    logic [15:0] total_cnt, fail_cnt;
    logic [2:0]  opc_sel = 3'd0;
    logic [7:0]  opc_fail_cnt;
    logic        first_vld;
    logic [2:0]  first_opc;
    logic [15:0] first_out1, first_out2;

    int checks = 0;
    int fails  = 0;

    alu_pair_checker_if #(.W(16)) bus ();

    alu_pair_checker #(.W(16), .SETTLE(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .smp          (bus.slave),
        .chk_done     (chk_done),
        .chk_fail     (chk_fail),
        .err_code     (err_code),
        .total_cnt    (total_cnt),
        .fail_cnt     (fail_cnt),
        .opc_sel      (opc_sel),
        .opc_fail_cnt (opc_fail_cnt),
        .first_vld    (first_vld),
        .first_opc    (first_opc),
        .first_out1   (first_out1),
        .first_out2   (first_out2)
    );

    always #5 clk = ~clk;

    // Drive one sample, wait (bounded) for chk_done, return after the REPORT edge.
    task automatic run_sample(input logic [2:0] o, input logic [15:0] a, input logic [15:0] b,
                              input logic z1, input logic n1, input logic z2, input logic n2,
                              input bit glitch, input bit hold,
                              output int lat, output logic [2:0] err, output logic fl);
        bus.opc = o; bus.out1 = a; bus.out2 = b;
        bus.zer1 = z1; bus.neg1 = n1; bus.zer2 = z2; bus.neg2 = n2;
        bus.smp_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) bus.smp_valid = 1'b0;
        if (glitch) bus.opc = ~o;
        lat = -1; err = '0; fl = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (chk_done) begin
                lat = i; err = err_code; fl = chk_fail;
                break;
            end
        end
        @(posedge clk); #1;
        bus.smp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (bus.smp_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%0b exp=1", bus.smp_ready); end
        checks++; if (chk_done !== 1'b0 || chk_fail !== 1'b0 || err_code !== 3'b000) begin fails++; $display("FAIL reset_outs got=%0b/%0b/%b exp=0/0/000", chk_done, chk_fail, err_code); end
        checks++; if (total_cnt !== 16'd0 || fail_cnt !== 16'd0 || opc_fail_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnts got=%0d/%0d/%0d exp=0/0/0", total_cnt, fail_cnt, opc_fail_cnt); end
        checks++; if (first_vld !== 1'b0 || first_out1 !== 16'd0 || first_out2 !== 16'd0 || first_opc !== 3'd0) begin fails++; $display("FAIL reset_first got=%0b/%h/%h/%0d exp=0/0/0/0", first_vld, first_out1, first_out2, first_opc); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_equal();
        int lat; logic [2:0] e; logic f;
        run_sample(3'd3, 16'h0009, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, e, f);
        checks++; if (lat != 5) begin fails++; $display("FAIL equal_latency got=%0d exp=5", lat); end
        checks++; if (f !== 1'b0 || e !== 3'b000) begin fails++; $display("FAIL equal_result got=%0b/%b exp=0/000", f, e); end
        checks++; if (total_cnt !== 16'd1 || fail_cnt !== 16'd0) begin fails++; $display("FAIL equal_cnts got=%0d/%0d exp=1/0", total_cnt, fail_cnt); end
    endtask

    task automatic test_mismatch();
        int lat; logic [2:0] e; logic f;
        run_sample(3'd1, 16'h0005, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, e, f);
        opc_sel = 3'd1; #1;
        checks++; if (lat != 5 || e !== 3'b001 || f !== 1'b1) begin fails++; $display("FAIL mismatch_err got=%0d/%b/%0b exp=5/001/1", lat, e, f); end
        checks++; if (fail_cnt !== 16'd1 || total_cnt !== 16'd2 || opc_fail_cnt !== 8'd1) begin fails++; $display("FAIL mismatch_cnts got=%0d/%0d/%0d exp=1/2/1", fail_cnt, total_cnt, opc_fail_cnt); end
        checks++; if (first_vld !== 1'b1 || first_opc !== 3'd1 || first_out1 !== 16'h0005 || first_out2 !== 16'h0004) begin fails++; $display("FAIL mismatch_first got=%0b/%0d/%h/%h exp=1/1/0005/0004", first_vld, first_opc, first_out1, first_out2); end
    endtask

    task automatic test_bad_flag();
        int lat; logic [2:0] e; logic f;
        run_sample(3'd2, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, e, f);
        checks++; if (lat != 5 || e !== 3'b110) begin fails++; $display("FAIL badflag_err got=%0d/%b exp=5/110", lat, e); end
        checks++; if (fail_cnt !== 16'd2) begin fails++; $display("FAIL badflag_cnt got=%0d exp=2", fail_cnt); end
        checks++; if (first_opc !== 3'd1 || first_out1 !== 16'h0005 || first_out2 !== 16'h0004) begin fails++; $display("FAIL badflag_first_kept got=%0d/%h/%h exp=1/0005/0004", first_opc, first_out1, first_out2); end
    endtask

    task automatic test_zero();
        int lat; logic [2:0] e; logic f;
        run_sample(3'd4, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lat, e, f);
        checks++; if (lat != 5 || e !== 3'b000 || f !== 1'b0) begin fails++; $display("FAIL zero_pass got=%0d/%b/%0b exp=5/000/0", lat, e, f); end
        run_sample(3'd4, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, e, f);
        checks++; if (lat != 5 || e !== 3'b110 || f !== 1'b1) begin fails++; $display("FAIL zero_bad got=%0d/%b/%0b exp=5/110/1", lat, e, f); end
        checks++; if (fail_cnt !== 16'd3 || total_cnt !== 16'd5) begin fails++; $display("FAIL zero_cnts got=%0d/%0d exp=3/5", fail_cnt, total_cnt); end
    endtask

    task automatic test_opc_glitch();
        int lat; logic [2:0] e; logic f;
        run_sample(3'd5, 16'h0005, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lat, e, f);
        opc_sel = 3'd5; #1;
        checks++; if (opc_fail_cnt !== 8'd1) begin fails++; $display("FAIL glitch_opc5 got=%0d exp=1", opc_fail_cnt); end
        opc_sel = 3'd2; #1;
        checks++; if (opc_fail_cnt !== 8'd1) begin fails++; $display("FAIL glitch_opc2 got=%0d exp=1", opc_fail_cnt); end
    endtask

    task automatic test_busy_ignore();
        int lat; logic [2:0] e; logic f;
        logic [15:0] t0;
        t0 = total_cnt;
        run_sample(3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, lat, e, f);
        checks++; if (lat != 5 || total_cnt !== t0 + 16'd1) begin fails++; $display("FAIL busy_single got=%0d/%0d exp=5/%0d", lat, total_cnt, t0 + 16'd1); end
        @(posedge clk); #1;
        checks++; if (bus.smp_ready !== 1'b1 || total_cnt !== t0 + 16'd1) begin fails++; $display("FAIL busy_idle got=%0b/%0d exp=1/%0d", bus.smp_ready, total_cnt, t0 + 16'd1); end
    endtask

    task automatic test_clr_settle();
        int seen = 0;
        bus.opc = 3'd1; bus.out1 = 16'h0005; bus.out2 = 16'h0004;
        bus.smp_valid = 1'b1;
        @(posedge clk); #1; bus.smp_valid = 1'b0;
        @(posedge clk); #1; clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        opc_sel = 3'd1; #1;
        checks++; if (bus.smp_ready !== 1'b1) begin fails++; $display("FAIL clr_ready got=%0b exp=1", bus.smp_ready); end
        checks++; if (total_cnt !== 16'd0 || fail_cnt !== 16'd0 || opc_fail_cnt !== 8'd0 || first_vld !== 1'b0 || first_out1 !== 16'd0) begin fails++; $display("FAIL clr_cnts got=%0d/%0d/%0d/%0b/%h exp=0/0/0/0/0", total_cnt, fail_cnt, opc_fail_cnt, first_vld, first_out1); end
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (chk_done) seen++; end
        checks++; if (seen != 0) begin fails++; $display("FAIL clr_no_done got=%0d exp=0", seen); end
    endtask

    task automatic test_rst_mid();
        int lat; int seen = 0; logic [2:0] e; logic f;
        run_sample(3'd3, 16'h0009, 16'h0009, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, e, f);
        checks++; if (total_cnt !== 16'd1) begin fails++; $display("FAIL rstmid_pre got=%0d exp=1", total_cnt); end
        bus.smp_valid = 1'b1;
        @(posedge clk); #1; bus.smp_valid = 1'b0;
        @(posedge clk); #1; rst_n = 1'b0;
        #1;
        checks++; if (bus.smp_ready !== 1'b1 || total_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_state got=%0b/%0d exp=1/0", bus.smp_ready, total_cnt); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (chk_done) seen++; end
        checks++; if (seen != 0 || total_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_no_done got=%0d/%0d exp=0/0", seen, total_cnt); end
    endtask

    task automatic test_clr_report();
        int lat = -1;
        bus.opc = 3'd1; bus.out1 = 16'h0005; bus.out2 = 16'h0004;
        bus.zer1 = 1'b0; bus.neg1 = 1'b0; bus.zer2 = 1'b0; bus.neg2 = 1'b0;
        bus.smp_valid = 1'b1;
        @(posedge clk); #1; bus.smp_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (chk_done) begin lat = i; break; end
        end
        clr = 1'b1; #1;
        checks++; if (lat != 5 || chk_done !== 1'b0) begin fails++; $display("FAIL clrrep_done got=%0d/%0b exp=5/0", lat, chk_done); end
        @(posedge clk); #1; clr = 1'b0;
        checks++; if (total_cnt !== 16'd0 || fail_cnt !== 16'd0 || first_vld !== 1'b0) begin fails++; $display("FAIL clrrep_cnts got=%0d/%0d/%0b exp=0/0/0", total_cnt, fail_cnt, first_vld); end
    endtask

    task automatic test_saturation();
        int lat; logic [2:0] e; logic f;
        opc_sel = 3'd6;
        for (int n = 0; n < 255; n++)
            run_sample(3'd6, 16'h0005, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, e, f);
        #1;
        checks++; if (opc_fail_cnt !== 8'hFF || fail_cnt !== 16'd255) begin fails++; $display("FAIL sat_255 got=%0d/%0d exp=255/255", opc_fail_cnt, fail_cnt); end
        run_sample(3'd6, 16'h0005, 16'h0004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, e, f);
        #1;
        checks++; if (opc_fail_cnt !== 8'hFF || fail_cnt !== 16'd256 || total_cnt !== 16'd256) begin fails++; $display("FAIL sat_256 got=%0d/%0d/%0d exp=255/256/256", opc_fail_cnt, fail_cnt, total_cnt); end
    endtask

    initial begin
        bus.smp_valid = 1'b0; bus.opc = '0; bus.out1 = '0; bus.out2 = '0;
        bus.zer1 = 1'b0; bus.neg1 = 1'b0; bus.zer2 = 1'b0; bus.neg2 = 1'b0;
        test_reset();
        test_equal();
        test_mismatch();
        test_bad_flag();
        test_zero();
        test_opc_glitch();
        test_busy_ignore();
        test_clr_settle();
        test_rst_mid();
        test_clr_report();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/alu_pair_checker.md
ALU_PAIR_CHECKER -- requirements
Module: alu_pair_checker

Interface
REQ-001 Parameter W, default 16, ALU data width.
REQ-002 Parameter SETTLE, default 4, cycles waited between sample acceptance and compare (legal 1..15).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 clr  in  1  synchronous clear of all counters and the first-fail record.
REQ-006 smp_valid  in  1  request to check the current ALU pair outputs.
REQ-007 smp_ready  out  1  checker can accept a request.
REQ-008 opc  in  3  opcode applied to both ALUs.
REQ-009 out1, out2  in  W  result of ALU implementation 1 and 2.
REQ-010 zer1, neg1, zer2, neg2  in  1  zero and negative flags of each implementation.
REQ-011 chk_done  out  1  one-cycle pulse when a compare completes.
REQ-012 chk_fail  out  1  valid with chk_done; any error bit set.
REQ-013 err_code  out  3  bit0 out1!=out2; bit1 {zer1,neg1}!={zer2,neg2}; bit2 either implementation's flags inconsistent with its own data.
REQ-014 total_cnt, fail_cnt  out  16  completed compares and failed compares.
REQ-015 opc_sel  in  3; opc_fail_cnt  out  8  failure count for opcode opc_sel (combinational read).
REQ-016 first_vld  out  1; first_opc  out  3; first_out1, first_out2  out  W  record of the first failure since reset/clr.

Function
REQ-017 FSM states IDLE, SETTLE, CMP, REPORT; smp_ready = 1 only in IDLE.
REQ-018 IDLE: smp_valid & smp_ready captures opc into opc_q, loads wait counter with SETTLE-1, moves to SETTLE.
REQ-019 SETTLE: counter decrements each cycle; at 0 moves to CMP (compare occurs exactly SETTLE+1 cycles after acceptance edge).
REQ-020 CMP: registers out1, out2 and flags, computes err_code; moves to REPORT.
REQ-021 Flag consistency: zerX must equal (outX==0) and negX must equal outX[W-1], X = 1, 2.
REQ-022 REPORT: chk_done=1 for one cycle; total_cnt+1; if fail, fail_cnt+1 and opc_fail_cnt[opc_q]+1; returns to IDLE.
REQ-023 All counters saturate (total/fail at 16'hFFFF, per-opcode at 8'hFF); no wrap.
REQ-024 First-fail record loads only when first_vld=0 and a failure is reported; first_vld then stays 1 until reset or clr.
REQ-025 Opcode used for bookkeeping is opc_q, not live opc; opc changes during SETTLE have no effect.
REQ-026 clr in any state: counters, per-opcode array and first-fail record zeroed next edge; FSM forced to IDLE; chk_done suppressed that cycle.
REQ-027 clr and a REPORT in the same cycle: clr wins, counters read 0.
REQ-028 smp_valid while not ready is ignored (no queueing).
REQ-029 Per-opcode read of opc_sel reflects update on the cycle after REPORT.

Reset
REQ-030 rst_n low: FSM IDLE, smp_ready=1, chk_done=0, chk_fail=0, err_code=0, all counters 0, first_vld=0, first_* data 0, opc_q=0.
REQ-031 Reset asserted mid-check aborts it; no counter changes, no chk_done.

Structure
REQ-032 Shared package alu_chk_pkg: state enum, err_code bit index constants, OPC_W=3, NUM_OPC=8, counter widths.
REQ-033 One sub-module alu_flag_check (combinational: data, zer, neg -> consistent bit), instantiated twice.

Verification
REQ-034 Equal pair: out1=out2=16'h0009, flags 0/0, opc=3 -> chk_done 5 cycles after accept, chk_fail=0, total_cnt=1.
REQ-035 Data mismatch: out1=16'h0005, out2=16'h0004, opc=1 -> err_code=3'b001, fail_cnt=1, opc_fail_cnt[1]=1, first_out1=5, first_out2=4.
REQ-036 Bad flag: out1=out2=16'h8000, neg1=1, neg2=0 -> err_code=3'b110; second failure later leaves first_* unchanged.
REQ-037 Zero case: out1=out2=0, zer1=zer2=1 -> pass; same with zer2=0 -> err_code=3'b110.
REQ-038 Saturation: 256 failures on opc=6 -> opc_fail_cnt[6]=8'hFF, fail_cnt=256.
REQ-039 clr asserted during SETTLE -> no chk_done, all counters 0, smp_ready=1 next cycle; rst_n pulse mid-SETTLE -> same.
